// File: rtl/adder_arbiter.sv
// Four-requester arbiter sharing one three-operand adder, one op in flight.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (0 highest) instead of round-robin.
module adder_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req_valid,
    output logic [3:0]         req_ready,
    input  logic [4*WIDTH-1:0] req_a,
    input  logic [4*WIDTH-1:0] req_b,
    input  logic [4*WIDTH-1:0] req_c,
    input  logic [3:0]         req_cin,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_id,
    output logic [WIDTH-1:0]   rsp_sum,
    output logic [1:0]         rsp_carry
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_c;
    logic             op_cin;
    logic [1:0]       op_id;

    logic [WIDTH-1:0] a_arr [4];
    logic [WIDTH-1:0] b_arr [4];
    logic [WIDTH-1:0] c_arr [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = req_a[i*WIDTH +: WIDTH];
            b_arr[i] = req_b[i*WIDTH +: WIDTH];
            c_arr[i] = req_c[i*WIDTH +: WIDTH];
        end
    end

    logic [3:0] rot;
    logic [1:0] off;
    logic [1:0] gnt_idx;
    logic       gnt_any;

`ifdef ADDER_ARB_FIXED_PRIO_EN
    assign rot     = req_valid;
    assign gnt_idx = off;
`else
    logic [1:0] ptr;
    logic [7:0] dbl;

    // rot[k] is the request at position ptr+k, so the lowest set bit wins
    assign dbl     = {req_valid, req_valid};
    assign rot     = dbl[ptr +: 4];
    assign gnt_idx = ptr + off;
`endif

    always_comb begin
        off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) off = 2'(k);
        end
    end

    assign gnt_any = |req_valid;

    always_comb begin
        req_ready = 4'b0000;
        if (rst_n && state == IDLE && gnt_any)
            req_ready = 4'b0001 << gnt_idx;
    end

    logic [WIDTH+1:0] sum;

    assign sum = {2'b00, op_a} + {2'b00, op_b} + {2'b00, op_c}
               + {{(WIDTH+1){1'b0}}, op_cin};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            ptr       <= 2'd0;
`endif
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 2'd0;
            rsp_id    <= 2'd0;
            op_a      <= '0;
            op_b      <= '0;
            op_c      <= '0;
            op_cin    <= 1'b0;
            op_id     <= 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        op_a   <= a_arr[gnt_idx];
                        op_b   <= b_arr[gnt_idx];
                        op_c   <= c_arr[gnt_idx];
                        op_cin <= req_cin[gnt_idx];
                        op_id  <= gnt_idx;
`ifndef ADDER_ARB_FIXED_PRIO_EN
                        ptr    <= gnt_idx + 2'd1;
`endif
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum   <= sum[WIDTH-1:0];
                    rsp_carry <= sum[WIDTH+1:WIDTH];
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed cases plus random traffic
// against a grant/sum reference model.
module tb_adder_arbiter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req_valid;
    logic [3:0]     req_ready;
    logic [4*W-1:0] req_a;
    logic [4*W-1:0] req_b;
    logic [4*W-1:0] req_c;
    logic [3:0]     req_cin;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic [1:0]     rsp_carry;

    logic [W-1:0] ra [4];
    logic [W-1:0] rb [4];
    logic [W-1:0] rc [4];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_a[i*W +: W] = ra[i];
            req_b[i*W +: W] = rb[i];
            req_c[i*W +: W] = rc[i];
        end
    end

    adder_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry)
    );

    int           ntests = 0;
    int           nfail  = 0;
    int           mptr   = 0;
    logic [W-1:0] last_sum;
    logic [1:0]   last_carry;
    logic [1:0]   last_id;
    logic [1:0]   seen_id;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
            if (v[k]) return k;
`else
            if (v[(mptr + k) % 4]) return (mptr + k) % 4;
`endif
        end
        return -1;
    endfunction

    task automatic rand_ops(input int i);
        if ($urandom_range(0, 3) == 0) begin
            ra[i] = '1;
            rb[i] = '1;
            rc[i] = '1;
        end else begin
            ra[i] = $urandom;
            rb[i] = $urandom;
            rc[i] = $urandom;
        end
        req_cin[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic model_reset();
        mptr       = 0;
        last_sum   = '0;
        last_carry = 2'd0;
        last_id    = 2'd0;
    endtask

    // Entered just after a rising edge with the DUT idle.
    task automatic txn(input logic [3:0] v, input int hold, input bit keep);
        int           g;
        logic [W+1:0] e;
        req_valid = v;
        g = model_grant(v);
        @(negedge clk);
        check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
        check("grant", 64'(req_ready), 64'(4'b0001 << g));
        e = {2'b00, ra[g]} + {2'b00, rb[g]} + {2'b00, rc[g]}
          + (W+2)'(req_cin[g]);
        @(posedge clk); #1;
        mptr = (g + 1) % 4;
        if (!keep) req_valid[g] = 1'b0;
        rand_ops(g);
        @(negedge clk);
        check("calc_rsp_valid", 64'(rsp_valid), 64'd0);
        check("calc_ready", 64'(req_ready), 64'd0);
        check("calc_hold_sum", 64'(rsp_sum), 64'(last_sum));
        check("calc_hold_carry", 64'(rsp_carry), 64'(last_carry));
        check("calc_hold_id", 64'(rsp_id), 64'(last_id));
        @(posedge clk); #1;
        for (int j = 0; j <= hold; j++) begin
            rsp_ready = (j == hold);
            @(negedge clk);
            check("resp_valid", 64'(rsp_valid), 64'd1);
            check("resp_sum", 64'(rsp_sum), 64'(e[W-1:0]));
            check("resp_carry", 64'(rsp_carry), 64'(e[W+1:W]));
            check("resp_id", 64'(rsp_id), 64'(g));
            check("resp_ready_low", 64'(req_ready), 64'd0);
            seen_id = rsp_id;
            @(posedge clk); #1;
        end
        last_sum   = e[W-1:0];
        last_carry = e[W+1:W];
        last_id    = 2'(g);
    endtask

    task automatic idle_cycle();
        req_valid = 4'b0000;
        @(negedge clk);
        check("idle_ready", 64'(req_ready), 64'd0);
        check("idle_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0] rr_seq [5];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) rand_ops(i);
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_sum", 64'(rsp_sum), 64'd0);
        check("rst_carry", 64'(rsp_carry), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        model_reset();
        idle_cycle();

        ra[0] = 32'd1;
        rb[0] = 32'd3;
        rc[0] = 32'd1;
        req_cin[0] = 1'b0;
        txn(4'b0001, 0, 1'b0);

        ra[2] = 32'hFFFF_FFFF;
        rb[2] = 32'hFFFF_FFFF;
        rc[2] = 32'hFFFF_FFFF;
        req_cin[2] = 1'b1;
        txn(4'b0100, 0, 1'b0);

        txn(4'b0110, 5, 1'b1);
        idle_cycle();

        req_valid = 4'b0010;
        @(negedge clk);
        check("pre_rst_grant", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        rst_n     = 1'b0;
        @(negedge clk);
        check("calc_rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("discard_valid", 64'(rsp_valid), 64'd0);
            check("discard_sum", 64'(rsp_sum), 64'd0);
            @(posedge clk); #1;
        end
        txn(4'b1010, 0, 1'b0);
        txn(4'b1000, 0, 1'b0);

        model_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            txn(4'b1111, 0, 1'b1);
`ifdef ADDER_ARB_FIXED_PRIO_EN
            check("seq_fixed", 64'(seen_id), 64'd0);
`else
            check("seq_rr", 64'(seen_id), 64'(rr_seq[i]));
`endif
        end

        for (int n = 0; n < 30; n++) begin
            logic [3:0] v;
            v = 4'($urandom_range(0, 15));
            if (v == 4'b0000)
                idle_cycle();
            else
                txn(v, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter: WIDTH, 32, operand and sum width.
REQ-002 The block SHALL have port: clk  in  1  single clock; all logic rising-edge.
REQ-003 The block SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port: req_valid  in  4  per-requester operation request.
REQ-005 The block SHALL have port: req_ready  out  4  per-requester accept strobe, at most one bit high.
REQ-006 The block SHALL have port: req_a  in  4*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have ports req_b and req_c: in  4*WIDTH  operands B and C, packed as req_a.
REQ-008 The block SHALL have port: req_cin  in  4  per-requester carry-in.
REQ-009 The block SHALL have port: rsp_valid  out  1  result available.
REQ-010 The block SHALL have port: rsp_ready  in  1  result consumer accepts.
REQ-011 The block SHALL have port: rsp_id  out  2  index of requester owning the result.
REQ-012 The block SHALL have ports rsp_sum (out, WIDTH) and rsp_carry (out, 2): low WIDTH bits and bits [WIDTH+1:WIDTH] of A+B+C+Cin.

Function
REQ-013 The block SHALL share one three-operand adder among 4 requesters, one operation in flight.
REQ-014 The FSM SHALL have states IDLE, CALC and RESP.
REQ-015 In IDLE with any req_valid high, the block SHALL combinationally assert req_ready for the granted requester only, latch its operands, cin and index, and go to CALC.
REQ-016 In IDLE with no req_valid, req_ready SHALL be 0 and the state SHALL remain IDLE.
REQ-017 Handshake: a request SHALL transfer in the cycle req_valid[i] and req_ready[i] are both high; requesters hold operands stable until then.
REQ-018 CALC SHALL register the WIDTH+2-bit sum A+B+C+Cin (no truncation) into rsp_sum/rsp_carry and go to RESP unconditionally.
REQ-019 In RESP, rsp_valid SHALL be 1, with rsp_sum, rsp_carry and rsp_id stable until rsp_ready is sampled high, then the state SHALL return to IDLE.
REQ-020 Latency: accept in cycle N SHALL give rsp_valid in cycle N+2; with rsp_ready tied high, throughput SHALL be one operation per 3 cycles.
REQ-021 req_ready SHALL be 0 in CALC and RESP; new requests SHALL wait regardless of rsp_ready.
REQ-022 Round-robin arbitration: 2-bit pointer ptr; grant the first valid requester searching ptr, ptr+1, ... mod 4; on grant g, ptr SHALL become (g+1) mod 4.
REQ-023 A requester dropping req_valid before grant SHALL not be granted; grant SHALL be re-evaluated every IDLE cycle.
REQ-024 rsp_sum, rsp_carry and rsp_id SHALL hold their last values outside RESP; only rsp_valid qualifies them.

Reset
REQ-025 When rst_n is sampled low, the state SHALL become IDLE, ptr 0, rsp_valid 0, rsp_sum 0, rsp_carry 0, rsp_id 0, and req_ready 0 during reset.
REQ-026 Reset in CALC or RESP SHALL discard the in-flight operation with no response; arbitration restarts at requester 0.

Configuration
REQ-027 Macro ADDER_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (requester 0 highest, 3 lowest) and ptr SHALL be removed; when undefined, REQ-022 round-robin SHALL apply.

Verification
REQ-028 req_valid=0001, A=1, B=3, C=1, Cin=0 -> req_ready=0001 in cycle N; rsp_valid in N+2, rsp_sum=5, rsp_carry=0, rsp_id=0.
REQ-029 Requester 2: A=B=C=FFFFFFFF, Cin=1 -> rsp_sum=FFFFFFFE, rsp_carry=2, rsp_id=2.
REQ-030 req_valid=1111 held, rsp_ready=1, round-robin -> rsp_id sequence 0,1,2,3,0; with ADDER_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-031 rsp_ready=0 for 5 cycles in RESP -> rsp_valid and outputs stable, req_ready=0; release -> IDLE next cycle, next grant follows.
REQ-032 rst_n low one cycle in CALC -> no rsp_valid, next request from req_valid=1000 granted to requester 3 with ptr restarted at 0.
